// File: rtl/pe_simd_acc.sv
// Systolic matrix-multiply PE: signed weight x sign-magnitude operand, saturating
// accumulate onto the neighbour's partial sum, full-width or two independent half lanes.
module pe_simd_acc #(
  parameter int DW = 16,
  parameter int AW = 32
) (
  input  logic          clk,
  input  logic          _res,
  input  logic [1:0]    mode,
  input  logic          vin,
  input  logic [DW-1:0] Win,
  input  logic          Wld,
  input  logic          Wswap,
  output logic [DW-1:0] Wpass,
  input  logic [DW-1:0] Xin,
  input  logic [1:0]    Xsign,
  input  logic [AW-1:0] Sin,
  output logic [1:0]    mpass,
  output logic [DW-1:0] Xpass,
  output logic [1:0]    Xspass,
  output logic          vpass,
  output logic [AW-1:0] Spass,
  output logic          sat
);

  localparam int HW = DW / 2;
  localparam int HA = AW / 2;

  logic signed [DW-1:0]   shadow_w;
  logic signed [DW-1:0]   active_w;
  logic signed [2*DW-1:0] prod_full_p0;
  logic signed [DW-1:0]   prod_hi_p0;
  logic signed [DW-1:0]   prod_lo_p0;
  logic signed [AW-1:0]   prod_p0;
  logic signed [AW-1:0]   prod_p1;
  logic [1:0]             mode_p1;
  logic                   vld_p1;
  logic [HA:0]            add_hi_p1;
  logic [HA:0]            add_lo_p1;
  logic [AW:0]            add_full_p1;
  logic [AW-1:0]          sum_p1;
  logic                   ovf_p1;

  // Magnitude is widened by one bit so -x never overflows; -0 collapses to 0.
  function automatic logic signed [2*DW-1:0] mul_full(input logic signed [DW-1:0] w,
                                                      input logic [DW-1:0] x,
                                                      input logic neg);
    logic signed [DW:0]   xs;
    logic signed [2*DW:0] p;
    xs = $signed({1'b0, x});
    if (neg) xs = -xs;
    p = (2*DW+1)'(w) * (2*DW+1)'(xs);
    return p[2*DW-1:0];
  endfunction

  function automatic logic signed [DW-1:0] mul_half(input logic signed [HW-1:0] w,
                                                    input logic [HW-1:0] x,
                                                    input logic neg);
    logic signed [HW:0] xs;
    logic signed [DW:0] p;
    xs = $signed({1'b0, x});
    if (neg) xs = -xs;
    p = (DW+1)'(w) * (DW+1)'(xs);
    return p[DW-1:0];
  endfunction

  // Returns {overflow, clamped sum}.
  function automatic logic [AW:0] sat_add_full(input logic signed [AW-1:0] a,
                                               input logic signed [AW-1:0] b);
    logic signed [AW:0] s;
    s = (AW+1)'(a) + (AW+1)'(b);
    if (s[AW] != s[AW-1]) return {1'b1, s[AW], {(AW-1){~s[AW]}}};
    return {1'b0, s[AW-1:0]};
  endfunction

  function automatic logic [HA:0] sat_add_half(input logic signed [HA-1:0] a,
                                               input logic signed [HA-1:0] b);
    logic signed [HA:0] s;
    s = (HA+1)'(a) + (HA+1)'(b);
    if (s[HA] != s[HA-1]) return {1'b1, s[HA], {(HA-1){~s[HA]}}};
    return {1'b0, s[HA-1:0]};
  endfunction

  assign Wpass = shadow_w;

  // Stage 0 -> 1: product formed from the live operand and the active weight
  always_comb begin
    prod_full_p0 = mul_full(active_w, Xin, Xsign[1]);
    prod_hi_p0   = mul_half(active_w[DW-1:HW], Xin[DW-1:HW], Xsign[1]);
    prod_lo_p0   = mul_half(active_w[HW-1:0], Xin[HW-1:0], Xsign[0]);
    if (mode[0]) prod_p0 = {HA'(prod_hi_p0), HA'(prod_lo_p0)};
    else         prod_p0 = AW'(prod_full_p0);
  end

  // Stage 1 -> 2: saturating accumulate, lanes isolated in split mode
  always_comb begin
    add_hi_p1   = sat_add_half(Sin[AW-1:HA], prod_p1[AW-1:HA]);
    add_lo_p1   = sat_add_half(Sin[HA-1:0], prod_p1[HA-1:0]);
    add_full_p1 = sat_add_full(Sin, prod_p1);
    if (mode_p1[0]) begin
      sum_p1 = {add_hi_p1[HA-1:0], add_lo_p1[HA-1:0]};
      ovf_p1 = add_hi_p1[HA] | add_lo_p1[HA];
    end else begin
      sum_p1 = add_full_p1[AW-1:0];
      ovf_p1 = add_full_p1[AW];
    end
  end

  always_ff @(negedge clk) begin
    if (!_res) begin
      shadow_w <= '0;
      active_w <= '0;
      prod_p1  <= '0;
      mode_p1  <= '0;
      vld_p1   <= 1'b0;
      mpass    <= '0;
      Xpass    <= '0;
      Xspass   <= '0;
      vpass    <= 1'b0;
      Spass    <= '0;
      sat      <= 1'b0;
    end else begin
      if (Wld)   shadow_w <= Win;
      if (Wswap) active_w <= shadow_w;
      prod_p1 <= prod_p0;
      mode_p1 <= mode;
      vld_p1  <= vin;
      mpass   <= mode;
      Xpass   <= Xin;
      Xspass  <= Xsign;
      vpass   <= vin;
      if (vld_p1 && mode_p1[1]) begin
        Spass <= sum_p1;
        if (ovf_p1) sat <= 1'b1;
      end else begin
        Spass <= '0;
      end
    end
  end

endmodule

// File: tb/tb_pe_simd_acc.sv
// Directed bench for pe_simd_acc: two PEs chained systolically, expected values hand-computed.
module tb_pe_simd_acc;

  logic        clk = 1'b0;
  logic        _res;
  logic [1:0]  mode;
  logic        vin;
  logic [15:0] Win;
  logic        Wld, Wswap;
  logic [15:0] Xin;
  logic [1:0]  Xsign;
  logic [31:0] Sin;

  logic [15:0] Wpass0, Xpass0, Wpass1, Xpass1;
  logic [1:0]  mpass0, Xspass0, mpass1, Xspass1;
  logic        vpass0, sat0, vpass1, sat1;
  logic [31:0] Spass0, Spass1;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  pe_simd_acc #(.DW(16), .AW(32)) u0 (
    .clk(clk), ._res(_res), .mode(mode), .vin(vin), .Win(Win), .Wld(Wld), .Wswap(Wswap),
    .Wpass(Wpass0), .Xin(Xin), .Xsign(Xsign), .Sin(Sin), .mpass(mpass0), .Xpass(Xpass0),
    .Xspass(Xspass0), .vpass(vpass0), .Spass(Spass0), .sat(sat0)
  );

  pe_simd_acc #(.DW(16), .AW(32)) u1 (
    .clk(clk), ._res(_res), .mode(mpass0), .vin(vpass0), .Win(Wpass0), .Wld(Wld), .Wswap(Wswap),
    .Wpass(Wpass1), .Xin(Xpass0), .Xsign(Xspass0), .Sin(Spass0), .mpass(mpass1), .Xpass(Xpass1),
    .Xspass(Xspass1), .vpass(vpass1), .Spass(Spass1), .sat(sat1)
  );

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Inputs change on the rising edge; the DUT acts on the falling edge.
  task automatic step();
    @(posedge clk);
  endtask

  task automatic idle_inputs();
    mode = 2'b00; vin = 1'b0; Xin = '0; Xsign = '0; Sin = '0;
    Win = '0; Wld = 1'b0; Wswap = 1'b0;
  endtask

  task automatic load_w(input logic [15:0] w);
    Win = w; Wld = 1'b1; step();
    Wld = 1'b0; Wswap = 1'b1; step();
    Wswap = 1'b0; Win = '0;
  endtask

  task automatic op(input string tag, input logic [15:0] x, input logic [1:0] xs,
                    input logic [1:0] m, input logic v, input logic [31:0] s,
                    input logic [31:0] exp);
    Xin = x; Xsign = xs; mode = m; vin = v; Sin = '0;
    step();
    chk({tag, ".vpass"}, 64'(vpass0), 64'(v));
    chk({tag, ".mpass"}, 64'(mpass0), 64'(m));
    chk({tag, ".xpass"}, 64'(Xpass0), 64'(x));
    chk({tag, ".xspass"}, 64'(Xspass0), 64'(xs));
    Xin = '0; Xsign = '0; mode = '0; vin = 1'b0; Sin = s;
    step();
    chk({tag, ".spass"}, 64'(Spass0), 64'(exp));
    Sin = '0;
  endtask

  task automatic do_reset_random();
    _res = 1'b0;
    Xin = 16'($urandom); Xsign = 2'($urandom); Sin = $urandom; Win = 16'($urandom | 1);
    mode = 2'b11; vin = 1'b1; Wld = 1'b1; Wswap = 1'b1;
    step();
    chk("rst.wpass",  64'(Wpass0),  64'd0);
    chk("rst.xpass",  64'(Xpass0),  64'd0);
    chk("rst.xspass", 64'(Xspass0), 64'd0);
    chk("rst.mpass",  64'(mpass0),  64'd0);
    chk("rst.vpass",  64'(vpass0),  64'd0);
    chk("rst.spass",  64'(Spass0),  64'd0);
    chk("rst.sat",    64'(sat0),    64'd0);
    idle_inputs();
    _res = 1'b1;
  endtask

  initial begin
    idle_inputs();
    _res = 1'b0;
    step(); step();
    _res = 1'b1;

    // Full mode: -3 * 100 + 5
    load_w(16'hFFFD);
    op("full", 16'd100, 2'b00, 2'b10, 1'b1, 32'd5, 32'hFFFFFED9);
    chk("full.sat", 64'(sat0), 64'd0);

    // Split: hi 2*10+1 = 21, lo (-1)*(-3)+2 = 5
    load_w(16'h02FF);
    op("split", 16'h0A03, 2'b01, 2'b11, 1'b1, 32'h00010002, 32'h00150005);
    chk("split.sat", 64'(sat0), 64'd0);

    // Split saturation: lo -128*255 + -32768 clamps to 0x8000, hi 3*4+16 = 28
    load_w(16'h0380);
    op("satsplit", 16'h04FF, 2'b00, 2'b11, 1'b1, 32'h00108000, 32'h001C8000);
    chk("satsplit.sat", 64'(sat0), 64'd1);

    do_reset_random();

    // Full saturation and stickiness
    load_w(16'h7FFF);
    op("satfull", 16'hFFFF, 2'b00, 2'b10, 1'b1, 32'h7FFFFFFF, 32'h7FFFFFFF);
    chk("satfull.sat", 64'(sat0), 64'd1);
    op("sticky", 16'd1, 2'b00, 2'b10, 1'b1, 32'd0, 32'h00007FFF);
    chk("sticky.sat", 64'(sat0), 64'd1);
    op("negzero", 16'd0, 2'b10, 2'b10, 1'b1, 32'd7, 32'd7);

    // Stop and bubble
    op("stop", 16'd5, 2'b00, 2'b00, 1'b1, 32'd100, 32'd0);
    op("bubble", 16'd5, 2'b00, 2'b10, 1'b0, 32'd100, 32'd0);

    // Weight buffering across the two-PE chain
    do_reset_random();
    Win = 16'd3; Wld = 1'b1; step();
    Win = 16'd5; step();
    Wld = 1'b0; Wswap = 1'b1; step();
    Wswap = 1'b0;
    chk("chain.wpass0", 64'(Wpass0), 64'd5);
    chk("chain.wpass1", 64'(Wpass1), 64'd3);
    Xin = 16'd2; Xsign = 2'b00; mode = 2'b10; vin = 1'b1; Sin = '0; Wld = 1'b1; Win = 16'd7;
    step();
    Xin = '0; mode = '0; vin = 1'b0; Win = 16'd9;
    step();
    Wld = 1'b0; Win = '0;
    chk("chain.old.spass0", 64'(Spass0), 64'd10);
    step();
    chk("chain.old.spass1", 64'(Spass1), 64'd16);
    chk("chain.shift.wpass0", 64'(Wpass0), 64'd9);
    chk("chain.shift.wpass1", 64'(Wpass1), 64'd7);

    // Load and swap together: active takes the pre-edge shadow
    Win = 16'd11; Wld = 1'b1; Wswap = 1'b1;
    step();
    Win = '0; Wld = 1'b0; Wswap = 1'b0;
    chk("both.wpass0", 64'(Wpass0), 64'd11);
    chk("both.wpass1", 64'(Wpass1), 64'd9);
    Xin = 16'd1; mode = 2'b10; vin = 1'b1;
    step();
    Xin = '0; mode = '0; vin = 1'b0;
    step();
    chk("both.spass0", 64'(Spass0), 64'd9);
    step();
    chk("both.spass1", 64'(Spass1), 64'd16);
    chk("both.sat1", 64'(sat1), 64'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
